// File: rtl/ddr_sim_pkg.sv
// Shared types for the simulation-RAM burst reader: FSM state encoding and
// the layout of one output-buffer entry, which is {last, data}.
package ddr_sim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // The last flag sits directly above the data field of a buffer entry
  function automatic int entry_last_bit(input int data_w);
    return data_w;
  endfunction

endpackage

// File: rtl/ddr_sim_rd_fifo.sv
// Synchronous show-ahead FIFO: the head entry is visible on o_rdata whenever
// the FIFO is not empty, and it is consumed by i_pop.
module ddr_sim_rd_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  // A full FIFO still takes a push when the head leaves in the same cycle
  always_comb begin
    do_pop   = i_pop && (count_q != '0);
    do_push  = i_push && ((count_q != CNT_W'(DEPTH)) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= i_wdata;
  end

  assign o_rdata = mem_q[rd_ptr_q];
  assign o_empty = (count_q == '0);
  assign o_count = count_q;

endmodule

// File: rtl/ddr_sim_burst_reader.sv
// Burst read initiator for the 1-cycle-latency simulation RAM: walks an address
// range and hands the returned words out as a valid/ready stream with last/done.
module ddr_sim_burst_reader
  import ddr_sim_pkg::*;
#(
  parameter int DATA_R     = 8,
  parameter int DEPTH_R    = 8,
  parameter int LEN_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_cmd_valid,
  output logic               o_cmd_ready,
  input  logic [DEPTH_R-1:0] i_cmd_addr,
  input  logic [LEN_W-1:0]   i_cmd_len,
  output logic [DEPTH_R-1:0] o_raddr,
  input  logic [DATA_R-1:0]  i_rdata,
  output logic               o_data_valid,
  input  logic               i_data_ready,
  output logic [DATA_R-1:0]  o_data,
  output logic               o_data_last,
  output logic               o_done
);

  localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam int LAST_BIT = entry_last_bit(DATA_R);

  state_t             state_q, state_d;
  logic [DEPTH_R-1:0] raddr_q, raddr_d;
  logic [LEN_W-1:0]   remain_q, remain_d;
  logic               v1_q, v1_d;
  logic               last1_q, last1_d;
  logic               done_q, done_d;
  logic               issue;
  logic               drain_done;
  logic               pop;
  logic [CNT_W:0]     credit_used;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_empty;
  logic [DATA_R:0]    fifo_rdata;

  // Words already buffered plus the one still coming back from the RAM;
  // a same-cycle pop is deliberately not credited so the FIFO cannot overflow.
  assign credit_used = {1'b0, fifo_count} + {{CNT_W{1'b0}}, v1_q};
  assign pop         = !fifo_empty && i_data_ready;

  always_comb begin
    state_d    = state_q;
    raddr_d    = raddr_q;
    remain_d   = remain_q;
    v1_d       = 1'b0;
    last1_d    = 1'b0;
    done_d     = 1'b0;
    issue      = 1'b0;
    drain_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_cmd_valid) begin
          raddr_d  = i_cmd_addr;
          remain_d = i_cmd_len;
          if (i_cmd_len != '0) state_d = ST_READ;
          else                 done_d  = 1'b1;
        end
      end
      ST_READ: begin
        issue = (remain_q != '0) && (credit_used < (CNT_W + 1)'(FIFO_DEPTH));
        if (issue) begin
          raddr_d  = raddr_q + DEPTH_R'(1);
          remain_d = remain_q - LEN_W'(1);
          v1_d     = 1'b1;
          last1_d  = (remain_q == LEN_W'(1));
          if (remain_q == LEN_W'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!v1_q && fifo_empty) begin
          drain_done = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      raddr_q  <= '0;
      remain_q <= '0;
      v1_q     <= 1'b0;
      last1_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      raddr_q  <= raddr_d;
      remain_q <= remain_d;
      v1_q     <= v1_d;
      last1_q  <= last1_d;
      done_q   <= done_d;
    end
  end

  ddr_sim_rd_fifo #(
    .WIDTH (DATA_R + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (v1_q),
    .i_wdata ({last1_q, i_rdata}),
    .i_pop   (pop),
    .o_rdata (fifo_rdata),
    .o_empty (fifo_empty),
    .o_count (fifo_count)
  );

  // Empty bursts signal done from a flop; real bursts finish from DRAIN directly
  assign o_cmd_ready  = (state_q == ST_IDLE);
  assign o_raddr      = raddr_q;
  assign o_data_valid = !fifo_empty;
  assign o_data       = fifo_rdata[DATA_R-1:0];
  assign o_data_last  = !fifo_empty && fifo_rdata[LAST_BIT];
  assign o_done       = done_q || drain_done;

endmodule

// File: tb/tb_ddr_sim_burst_reader.sv
// Randomised bench for ddr_sim_burst_reader: two instances (4- and 2-deep
// buffers) each read a behavioural RAM preloaded with mem[k]=k.
module tb_ddr_sim_burst_reader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sel = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_addr = '0;
  logic [7:0] cmd_len = '0;
  logic       data_ready = 1'b0;

  logic       cmd_ready_a, valid_a, last_a, done_a;
  logic [7:0] raddr_a, rdata_a, data_a;
  logic       cmd_ready_b, valid_b, last_b, done_b;
  logic [7:0] raddr_b, rdata_b, data_b;

  logic       m_cmd_ready, m_valid, m_last, m_done;
  logic [7:0] m_raddr, m_data;

  logic [7:0] ram [256];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ddr_sim_burst_reader #(.DATA_R(8), .DEPTH_R(8), .LEN_W(8), .FIFO_DEPTH(4)) dut_a (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_cmd_valid  (cmd_valid && !sel),
    .o_cmd_ready  (cmd_ready_a),
    .i_cmd_addr   (cmd_addr),
    .i_cmd_len    (cmd_len),
    .o_raddr      (raddr_a),
    .i_rdata      (rdata_a),
    .o_data_valid (valid_a),
    .i_data_ready (data_ready && !sel),
    .o_data       (data_a),
    .o_data_last  (last_a),
    .o_done       (done_a)
  );

  ddr_sim_burst_reader #(.DATA_R(8), .DEPTH_R(8), .LEN_W(8), .FIFO_DEPTH(2)) dut_b (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_cmd_valid  (cmd_valid && sel),
    .o_cmd_ready  (cmd_ready_b),
    .i_cmd_addr   (cmd_addr),
    .i_cmd_len    (cmd_len),
    .o_raddr      (raddr_b),
    .i_rdata      (rdata_b),
    .o_data_valid (valid_b),
    .i_data_ready (data_ready && sel),
    .o_data       (data_b),
    .o_data_last  (last_b),
    .o_done       (done_b)
  );

  // Registered-read RAM models, one per instance
  always @(posedge clk) begin
    rdata_a <= ram[raddr_a];
    rdata_b <= ram[raddr_b];
  end

  assign m_cmd_ready = sel ? cmd_ready_b : cmd_ready_a;
  assign m_valid     = sel ? valid_b     : valid_a;
  assign m_last      = sel ? last_b      : last_a;
  assign m_done      = sel ? done_b      : done_a;
  assign m_raddr     = sel ? raddr_b     : raddr_a;
  assign m_data      = sel ? data_b      : data_a;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h exp=%0h (sel=%0d t=%0t)", tag, got, exp, sel, $time);
    end
  endtask

  // Holds reset low for two rising edges and checks both the reset and post-reset state
  task automatic resetDut();
    cmd_valid  = 1'b0;
    data_ready = 1'b0;
    rst_n      = 1'b0;
    @(negedge clk);
    checkOutput("rst_valid", m_valid, 0);
    checkOutput("rst_last", m_last, 0);
    checkOutput("rst_done", m_done, 0);
    checkOutput("rst_raddr", m_raddr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_ready", m_cmd_ready, 1);
    checkOutput("post_rst_valid", m_valid, 0);
  endtask

  // mode: 0 ready always high, 1 ready toggling, 2 ready random; stallAt>0 forces 5 low cycles;
  // rstAfter>0 pulls reset once that many beats have been handed over
  task automatic applyStimulus(input bit useB, input logic [7:0] addr, input int len,
                               input int mode, input int stallAt, input int rstAfter);
    logic [7:0] exp_data [$];
    int  cyc, beats, first_valid, done_cyc, waited;
    bit  seen_done, timed;
    sel       = useB;
    cmd_valid = 1'b0;
    waited    = 0;
    @(negedge clk);
    while (!m_cmd_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("cmd_ready_idle", m_cmd_ready, 1);
    for (int i = 0; i < len; i++) exp_data.push_back(ram[8'(addr + i)]);
    cmd_valid   = 1'b1;
    cmd_addr    = addr;
    cmd_len     = 8'(len);
    data_ready  = (mode == 0);
    cyc         = 0;
    beats       = 0;
    first_valid = -1;
    done_cyc    = -1;
    seen_done   = 1'b0;
    timed       = (mode == 0) && (stallAt == 0) && (rstAfter == 0);
    while (!seen_done && cyc < 4 * len + 40) begin
      @(negedge clk);
      cyc++;
      if (rstAfter > 0 && beats >= rstAfter) begin
        resetDut();
        return;
      end
      case (mode)
        0:       data_ready = 1'b1;
        1:       data_ready = (cyc % 2) == 1;
        default: data_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (stallAt > 0 && cyc >= stallAt && cyc < stallAt + 5) data_ready = 1'b0;
      if (cyc == 1) checkOutput("busy_ready", m_cmd_ready, len == 0);
      if (m_valid && first_valid < 0) first_valid = cyc;
      if (beats >= len) begin
        checkOutput("no_extra_valid", m_valid, 0);
      end else if (m_valid && data_ready) begin
        checkOutput("data", m_data, exp_data[beats]);
        checkOutput("last", m_last, beats == len - 1);
        beats++;
      end
      if (m_done) begin
        seen_done = 1'b1;
        done_cyc  = cyc;
        cmd_valid = 1'b0;
      end else begin
        // Commands offered while busy must be ignored
        cmd_valid = (len > 0) && ($urandom_range(0, 1) == 1);
        cmd_addr  = 8'($urandom);
        cmd_len   = 8'($urandom);
      end
    end
    cmd_valid = 1'b0;
    checkOutput("done_seen", seen_done, 1);
    checkOutput("beat_count", beats, len);
    if (timed && !useB) begin
      checkOutput("first_valid", first_valid, (len > 0) ? 3 : -1);
      checkOutput("done_cycle", done_cyc, (len > 0) ? len + 3 : 1);
    end
    if (timed && useB && len >= 4)
      checkOutput("d2_rate", (done_cyc > len + 3) && (done_cyc <= 2 * len + 4), 1);
    if (seen_done) begin
      @(negedge clk);
      checkOutput("ready_after_done", m_cmd_ready, 1);
      checkOutput("idle_no_valid", m_valid, 0);
    end
  endtask

  initial begin
    for (int k = 0; k < 256; k++) ram[k] = 8'(k);
    $display("[TB] starting ddr_sim_burst_reader bench");
    resetDut();

    applyStimulus(1'b0, 8'h10, 4, 0, 0, 0);
    applyStimulus(1'b0, 8'hFE, 4, 0, 0, 0);
    applyStimulus(1'b0, 8'h33, 0, 0, 0, 0);
    applyStimulus(1'b0, 8'h20, 16, 1, 6, 0);
    applyStimulus(1'b1, 8'h50, 8, 0, 0, 0);
    applyStimulus(1'b0, 8'h80, 8, 0, 0, 3);
    applyStimulus(1'b0, 8'h40, 2, 0, 0, 0);
    applyStimulus(1'b1, 8'hFD, 6, 1, 3, 0);

    for (int n = 0; n < 16; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), int'($urandom_range(0, 24)),
                    int'($urandom_range(0, 2)),
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 10)) : 0, 0);
    end
    applyStimulus(1'b0, 8'hF0, 255, 2, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
